// File: rtl/uart_prog_loader.sv
// UART boot loader: receives 8N1 bytes, parses a length-prefixed image of
// little-endian 32-bit words into instruction memory, then releases the core.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_input,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  loading,
    output logic                  done,
    output logic                  ferr,
    output logic                  overflow
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [32:0]     CAPACITY  = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_e;
    typedef enum logic [1:0] {L_LEN, L_WORD, L_DONE} ld_state_e;

    logic            sync1_q, sync2_q;
    logic            rx;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid, frame_err;

    ld_state_e              ld_state_q, ld_state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [31:0]            len_q, len_d;
    logic [31:0]            asm_q, asm_d;
    logic [31:0]            word_idx_q, word_idx_d;
    logic [31:0]            word_full;
    logic                   loading_q, loading_d;
    logic                   ferr_q, ferr_d;
    logic                   overflow_q, overflow_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;

    // State registers for synchroniser, receiver and loader.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= R_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            ld_state_q <= L_LEN;
            byte_cnt_q <= '0;
            len_q      <= '0;
            asm_q      <= '0;
            word_idx_q <= '0;
            loading_q  <= 1'b0;
            ferr_q     <= 1'b0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            sync1_q    <= uart_input;
            sync2_q    <= sync1_q;
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ld_state_q <= ld_state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            word_idx_q <= word_idx_d;
            loading_q  <= loading_d;
            ferr_q     <= ferr_d;
            overflow_q <= overflow_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign rx = sync2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        case (rx_state_q)
            R_IDLE: begin
                clk_cnt_d = '0;
                if (!rx) rx_state_d = R_START;
            end
            R_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx ? R_IDLE : R_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx ? R_IDLE : R_BREAK;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            R_BREAK: begin
                // Line held low through the stop bit: wait for idle before hunting a new start.
                if (rx) rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = (rx_state_q == R_STOP) && (clk_cnt_q == BIT_LAST) && rx;
        frame_err  = (rx_state_q == R_STOP) && (clk_cnt_q == BIT_LAST) && !rx;
    end

    // Bytes arrive LSB first, so shifting in from the top builds a little-endian word.
    assign word_full = {shift_q, asm_q[31:8]};

    always_comb begin
        ld_state_d = ld_state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        asm_d      = asm_q;
        word_idx_d = word_idx_q;
        loading_d  = loading_q;
        ferr_d     = ferr_q | frame_err;
        overflow_d = overflow_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (ld_state_q)
            L_LEN: begin
                if (byte_valid) begin
                    loading_d  = 1'b1;
                    asm_d      = word_full;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        len_d      = word_full;
                        word_idx_d = '0;
                        if ({1'b0, word_full} > CAPACITY) overflow_d = 1'b1;
                        if (word_full == 32'd0) begin
                            ld_state_d = L_DONE;
                            loading_d  = 1'b0;
                        end else begin
                            ld_state_d = L_WORD;
                        end
                    end
                end
            end
            L_WORD: begin
                if (byte_valid) begin
                    asm_d      = word_full;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        // Words beyond memory capacity are consumed without a strobe.
                        if ({1'b0, word_idx_q} < CAPACITY) begin
                            we_d    = 1'b1;
                            addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                            wdata_d = word_full;
                        end
                        word_idx_d = word_idx_q + 32'd1;
                        if (word_idx_q + 32'd1 == len_q) begin
                            ld_state_d = L_DONE;
                            loading_d  = 1'b0;
                        end
                    end
                end
            end
            L_DONE: ;
            default: ld_state_d = L_LEN;
        endcase
    end

    always_comb begin
        imem_we    = we_q;
        imem_addr  = addr_q;
        imem_wdata = wdata_q;
        done       = (ld_state_q == L_DONE);
        core_rst   = (ld_state_q != L_DONE);
        loading    = loading_q;
        ferr       = ferr_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: table of whole images plus hand-written
// sequences for glitch, framing error, overflow and mid-load reset.
module tb_uart_prog_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_input = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst, loading, done, ferr, overflow;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_input (uart_input),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .loading    (loading),
        .done       (done),
        .ferr       (ferr),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] got_q[$];

    // Every write strobe is captured as {addr, data}; a stuck strobe shows up as extras.
    always @(negedge clk) begin
        if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});
    end

    typedef struct {
        string           name;
        int              nbytes;
        logic [7:0]      bytes [16];
        int              nw;
        logic [1:0][31:0] w;
        logic            exp_done;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        uart_input = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_level);
        uart_input = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_input = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_input = stop_level;
        repeat (CPB) @(posedge clk);
        uart_input = 1'b1;
        repeat (stop_level ? 2 : CPB) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},       64'(imem_we),    64'd0);
        check({tag, "_addr"},     64'(imem_addr),  64'd0);
        check({tag, "_wdata"},    64'(imem_wdata), 64'd0);
        check({tag, "_core_rst"}, 64'(core_rst),   64'd1);
        check({tag, "_loading"},  64'(loading),    64'd0);
        check({tag, "_done"},     64'(done),       64'd0);
        check({tag, "_ferr"},     64'(ferr),       64'd0);
        check({tag, "_overflow"}, 64'(overflow),   64'd0);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag, input logic d, input logic l,
                                input logic fe, input logic ov);
        check({tag, "_done"},     64'(done),     64'(d));
        check({tag, "_core_rst"}, 64'(core_rst), 64'(!d));
        check({tag, "_loading"},  64'(loading),  64'(l));
        check({tag, "_ferr"},     64'(ferr),     64'(fe));
        check({tag, "_overflow"}, 64'(overflow), 64'(ov));
    endtask

    initial begin
        vecs[0].name = "two_word"; vecs[0].nbytes = 12; vecs[0].nw = 2;
        vecs[0].bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0].w = {32'hDEADBEEF, 32'h00100513}; vecs[0].exp_done = 1'b1;

        vecs[1].name = "zero_len_aa"; vecs[1].nbytes = 5; vecs[1].nw = 0;
        vecs[1].bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].w = '0; vecs[1].exp_done = 1'b1;

        vecs[2].name = "one_word"; vecs[2].nbytes = 8; vecs[2].nw = 1;
        vecs[2].bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].w = {32'h0, 32'h12345678}; vecs[2].exp_done = 1'b1;

        vecs[3].name = "partial"; vecs[3].nbytes = 12; vecs[3].nw = 2;
        vecs[3].bytes = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                          8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].w = {32'h08070605, 32'h04030201}; vecs[3].exp_done = 1'b0;

        do_reset();
        check_reset_values("reset");

        // Whole-image vectors.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int b = 0; b < vecs[v].nbytes; b++) send_byte(vecs[v].bytes[b], 1'b1);
            repeat (20) @(negedge clk);
            for (int k = 0; k < vecs[v].nw; k++) exp_q.push_back({AW'(k), vecs[v].w[k]});
            check_writes(vecs[v].name);
            check_status(vecs[v].name, vecs[v].exp_done, !vecs[v].exp_done, 1'b0, 1'b0);
        end

        // Zero-length: done and core release right after the 4th stop bit.
        do_reset();
        for (int b = 0; b < 4; b++) send_byte(8'h00, 1'b1);
        check_status("zero_imm", 1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b1);
        check_writes("zero_after");
        check_status("zero_after", 1'b1, 1'b0, 1'b0, 1'b0);

        // Short low glitch must not produce a byte.
        do_reset();
        uart_input = 1'b0;
        repeat (4) @(posedge clk);
        uart_input = 1'b1;
        repeat (40) @(negedge clk);
        check_status("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h01, 1'b1);
        for (int b = 0; b < 3; b++) send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        exp_q.push_back({AW'(0), 32'h44332211});
        check_writes("glitch");
        check_status("glitch_end", 1'b1, 1'b0, 1'b0, 1'b0);

        // Framing error inside the header: byte dropped, not counted.
        do_reset();
        send_byte(8'h55, 1'b0);
        check_status("ferr_hit", 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1);
        for (int b = 0; b < 3; b++) send_byte(8'h00, 1'b1);
        send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'h01, 1'b1);
        exp_q.push_back({AW'(0), 32'h01EFCDAB});
        check_writes("ferr");
        check_status("ferr_end", 1'b1, 1'b0, 1'b1, 1'b0);

        // Overflow: 18 words into a 16-word memory.
        do_reset();
        send_byte(8'h12, 1'b1);
        for (int b = 0; b < 3; b++) send_byte(8'h00, 1'b1);
        check_status("ovf_hdr", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 18; k++) begin
            send_byte(8'(k), 1'b1); send_byte(8'h5A, 1'b1);
            send_byte(8'hC3, 1'b1); send_byte(8'hA0, 1'b1);
            if (k < 16) exp_q.push_back({AW'(k), 32'hA0C35A00 | 32'(k)});
        end
        check_writes("ovf");
        check_status("ovf_end", 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset after 6 bytes and part of a 7th, then a full re-send.
        do_reset();
        for (int b = 0; b < 6; b++) send_byte(vecs[0].bytes[b], 1'b1);
        check_status("mid_pre", 1'b0, 1'b1, 1'b0, 1'b0);
        uart_input = 1'b0;
        repeat (CPB * 3) @(posedge clk);
        do_reset();
        check_reset_values("mid_rst");
        for (int b = 0; b < 11; b++) send_byte(vecs[0].bytes[b], 1'b1);
        check_status("mid_before_last", 1'b0, 1'b1, 1'b0, 1'b0);
        send_byte(vecs[0].bytes[11], 1'b1);
        exp_q.push_back({AW'(0), 32'h00100513});
        exp_q.push_back({AW'(1), 32'hDEADBEEF});
        check_writes("mid_resend");
        check_status("mid_end", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Receive-side boot loader on the host-to-board UART link. It deserialises 8N1 bytes from the serial input pin and parses a length-prefixed program image. The image is assembled into 32-bit little-endian words and written sequentially into instruction memory. The block holds the CPU core in reset via core_rst until loading completes.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4
ADDR_WIDTH, 12, instruction memory word-address width (capacity 2^ADDR_WIDTH words)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
uart_input  input  1  serial line, idle high, asynchronous to clk
imem_we  output  1  one-cycle write strobe to instruction memory
imem_addr  output  ADDR_WIDTH  word address of current write
imem_wdata  output  32  word being written
core_rst  output  1  high until image fully loaded; drives core reset
loading  output  1  high from first header byte until done
done  output  1  sticky: image complete
ferr  output  1  sticky: at least one framing error seen
overflow  output  1  sticky: header length exceeded capacity

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, loading=0, done=0, ferr=0, overflow=0. All counters and FSMs return to idle. The 2-FF synchroniser resets to 1.
- A rst mid-frame or mid-image discards all partial data; loading restarts from the header.
- Input synchronisation: uart_input passes through a 2-FF synchroniser. Only the synchronised value is used.
- Bit receiver FSM, states R_IDLE, R_START, R_DATA, R_STOP:
  - R_IDLE -> R_START on synchronised low.
  - R_START: wait CLKS_PER_BIT/2 cycles, then sample. Low -> R_DATA. High -> false start, back to R_IDLE with no byte emitted.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles. High -> emit byte (internal byte_valid pulse, 1 cycle). Low -> set ferr, drop the byte, wait for line high, then R_IDLE.
- Loader FSM, states L_LEN, L_WORD, L_DONE:
  - L_LEN: collect 4 bytes, little-endian, into word count N (32 bits). loading rises with the first byte.
  - After the 4th byte: N==0 -> L_DONE. Otherwise -> L_WORD. If N > 2^ADDR_WIDTH, set overflow.
  - L_WORD: collect 4 bytes, little-endian (first byte = bits 7:0).
  - On the 4th byte, exactly one cycle after its byte_valid: imem_we=1 for one cycle, imem_wdata=assembled word, imem_addr=word index (0,1,2,...).
  - Words with index >= 2^ADDR_WIDTH are consumed but suppress imem_we. imem_addr never wraps.
  - After word N-1 is consumed -> L_DONE.
  - L_DONE: done=1, loading=0; core_rst falls on the same cycle done rises. Further bytes are ignored. Only rst leaves L_DONE.
- Framing errors: a dropped byte does not advance the byte counter. The loader does not resynchronise; the host must re-send after rst.
- Widths: the byte counter within a word is 2 bits and wraps 3->0. The word counter is 32 bits and is compared against N.
- imem_addr and imem_wdata hold their last value between strobes.

Test Plan:
Benches use CLKS_PER_BIT=16 and ADDR_WIDTH=4.
1. Two-word image, bytes 02 00 00 00 13 05 10 00 EF BE AD DE -> writes addr0=0x00100513, then addr1=0xDEADBEEF. Exactly 2 imem_we pulses. core_rst 1->0 and done=1 after the last stop bit. ferr=0, overflow=0.
2. Zero-length image 00 00 00 00 -> no imem_we. done=1 and core_rst=0 immediately after the 4th byte. A following byte 0xAA is ignored.
3. Glitch: line low for 4 cycles, then high -> no byte emitted, FSM stays in L_LEN. A valid header sent afterwards is parsed correctly.
4. Framing error: a 0x55 frame with stop bit low inside the header -> ferr=1 and the byte is not counted. The next 4 valid bytes 01 00 00 00 form N=1.
5. Overflow: header 12 00 00 00 (N=18 > 16) -> overflow=1. Addresses 0..15 are written; words 16 and 17 are consumed with no strobe; then done=1.
6. Reset mid-load: assert rst after 6 bytes of scenario 1 -> all outputs return to reset values. Re-sending the full image reproduces scenario 1 results.
